// File: rtl/ram_table_writer.sv
// Write-side command engine for a quadtree level RAM: turns WRITE and FILL
// commands into a one-word-per-clock RAM write port with done/err pulses.
module ram_table_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]            state_q;
  logic [CNT_W-1:0]      remain_q;
  logic                  ready_q;
  logic                  wr_enable_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic                  bad_cmd;
  logic [CNT_W-1:0]      end_sum;
  logic [CNT_W-1:0]      load_count;

  assign accept = ready_q & cmd_valid_i;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    bad_cmd    = 1'b0;
    load_count = CNT_W'(1);
    // The sum is one bit wider than an address, so it cannot wrap while
    // len <= DEPTH; larger lengths are rejected on their own.
    end_sum    = {1'b0, cmd_addr_i} + cmd_len_i;
    if (cmd_op_i == OP_FILL) begin
      load_count = cmd_len_i;
      if ((cmd_len_i == '0) || (cmd_len_i > DEPTH) || (end_sum > DEPTH)) begin
        bad_cmd = 1'b1;
      end
    end else if (cmd_op_i != OP_WRITE) begin
      bad_cmd = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      ready_q     <= 1'b0;
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && bad_cmd) begin
            state_q     <= ST_ERR;
            ready_q     <= 1'b0;
            wr_enable_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else if (accept) begin
            // First write goes out in the cycle right after the accept edge.
            state_q     <= ST_RUN;
            ready_q     <= 1'b0;
            remain_q    <= load_count;
            wr_enable_q <= 1'b1;
            wr_addr_q   <= cmd_addr_i;
            wr_data_q   <= cmd_data_i;
            done_q      <= (load_count == CNT_W'(1));
            err_q       <= 1'b0;
          end else begin
            ready_q     <= 1'b1;
            wr_enable_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end

        ST_RUN: begin
          // remain_q counts the word currently on the port plus those after it.
          if (remain_q == CNT_W'(1)) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            wr_enable_q <= 1'b0;
            done_q      <= 1'b0;
          end else begin
            remain_q    <= remain_q - CNT_W'(1);
            wr_addr_q   <= wr_addr_q + ADDR_WIDTH'(1);
            wr_enable_q <= 1'b1;
            done_q      <= (remain_q == CNT_W'(2));
          end
        end

        ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          ready_q     <= 1'b1;
          wr_enable_q <= 1'b0;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign wr_enable_o = wr_enable_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ram_table_writer.sv
// Self-checking bench for ram_table_writer: a scoreboard queue of expected
// RAM writes is filled as commands are issued and drained by a write monitor.
module tb_ram_table_writer;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int CW = AW + 1;

  logic          clk_i;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic [CW-1:0] cmd_len_i;
  logic [DW-1:0] wr_data_o;
  logic [AW-1:0] wr_addr_o;
  logic          wr_enable_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  ram_table_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_len_i   (cmd_len_i),
    .wr_data_o   (wr_data_o),
    .wr_addr_o   (wr_addr_o),
    .wr_enable_o (wr_enable_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Every strobe seen on the write port must match the next expected write.
  task automatic monitor_writes();
    wr_t e;
    forever begin
      @(negedge clk_i);
      if (wr_enable_o === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_write: got addr=%0d data=%h done=%b, required no write",
                   wr_addr_o, wr_data_o, done_o);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr_o !== e.addr || wr_data_o !== e.data || done_o !== e.last ||
              err_o !== 1'b0) begin
            n_mis++;
            $display("FAIL write_scoreboard: got addr=%0d data=%h done=%b err=%b, required addr=%0d data=%h done=%b err=0",
                     wr_addr_o, wr_data_o, done_o, err_o, e.addr, e.data, e.last);
          end
        end
      end
    end
  endtask

  task automatic push_writes(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int count, input bit mark_last);
    wr_t e;
    logic [AW-1:0] a;
    a = addr;
    for (int i = 0; i < count; i++) begin
      e.addr = a;
      e.data = data;
      e.last = mark_last && (i == count - 1);
      exp_q.push_back(e);
      a = a + AW'(1);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [CW-1:0] len);
    int waited;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    cmd_len_i   = len;
    waited      = 0;
    while (cmd_ready_o !== 1'b1 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (cmd_ready_o !== 1'b1) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: got ready=%b after %0d cycles, required ready=1", cmd_ready_o, waited);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1 || wr_enable_o !== 1'b0 ||
        wr_addr_o !== '0 || wr_data_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_values: got ready=%b busy=%b we=%b addr=%0d data=%h done=%b err=%b, required 0 1 0 0 00 0 0",
               cmd_ready_o, busy_o, wr_enable_o, wr_addr_o, wr_data_o, done_o, err_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    push_writes(addr, data, 1, 1'b1);
    send_cmd(2'd0, addr, data, CW'(0));
    n_cmp++;
    if (wr_enable_o !== 1'b1 || wr_addr_o !== addr || wr_data_o !== data ||
        done_o !== 1'b1 || cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_mis++;
      $display("FAIL write_first_cycle: got we=%b addr=%0d data=%h done=%b ready=%b busy=%b, required 1 %0d %h 1 0 1",
               wr_enable_o, wr_addr_o, wr_data_o, done_o, cmd_ready_o, busy_o, addr, data);
    end
    @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || wr_enable_o !== 1'b0 || done_o !== 1'b0 ||
        wr_addr_o !== addr || wr_data_o !== data) begin
      n_mis++;
      $display("FAIL write_after: got ready=%b we=%b done=%b addr=%0d data=%h, required 1 0 0 %0d %h",
               cmd_ready_o, wr_enable_o, done_o, wr_addr_o, wr_data_o, addr, data);
    end
  endtask

  task automatic test_fill_top();
    int c;
    push_writes(AW'(60), 8'h11, 4, 1'b1);
    send_cmd(2'd1, AW'(60), 8'h11, CW'(4));
    c = 1;
    while (done_o !== 1'b1 && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    n_cmp++;
    if (c != 4 || wr_addr_o !== AW'(63) || wr_enable_o !== 1'b1) begin
      n_mis++;
      $display("FAIL fill_top_done: got cycle=%0d addr=%0d we=%b, required cycle=4 addr=63 we=1",
               c, wr_addr_o, wr_enable_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (wr_enable_o !== 1'b0 || cmd_ready_o !== 1'b1 || exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL fill_top_end: got we=%b ready=%b pending=%0d, required 0 1 0",
               wr_enable_o, cmd_ready_o, exp_q.size());
    end
  endtask

  task automatic test_reject(input string name, input logic [1:0] op,
                             input logic [AW-1:0] addr, input logic [CW-1:0] len);
    send_cmd(op, addr, 8'hEE, len);
    n_cmp++;
    if (done_o !== 1'b1 || err_o !== 1'b1 || wr_enable_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_err_pulse: got done=%b err=%b we=%b ready=%b, required 1 1 0 0",
               name, done_o, err_o, wr_enable_o, cmd_ready_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || wr_enable_o !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_recover: got ready=%b done=%b err=%b we=%b, required 1 0 0 0",
               name, cmd_ready_o, done_o, err_o, wr_enable_o);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int done_c;
    push_writes(AW'(0), 8'h5C, 64, 1'b1);
    push_writes(AW'(7), 8'h3D, 1, 1'b1);
    send_cmd(2'd1, AW'(0), 8'h5C, CW'(64));
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'd0;
    cmd_addr_i  = AW'(7);
    cmd_data_i  = 8'h3D;
    cmd_len_i   = CW'(0);
    c      = 1;
    done_c = 0;
    while (c < 300) begin
      if (done_o === 1'b1 && done_c == 0) done_c = c;
      if (cmd_ready_o === 1'b1) break;
      @(negedge clk_i);
      c++;
    end
    n_cmp++;
    if (c != 65 || done_c != 64) begin
      n_mis++;
      $display("FAIL full_fill_timing: got ready_cycle=%0d done_cycle=%0d, required 65 64", c, done_c);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (wr_enable_o !== 1'b1 || wr_addr_o !== AW'(7) || wr_data_o !== 8'h3D || done_o !== 1'b1) begin
      n_mis++;
      $display("FAIL held_cmd_write: got we=%b addr=%0d data=%h done=%b, required 1 7 3d 1",
               wr_enable_o, wr_addr_o, wr_data_o, done_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_during_run();
    push_writes(AW'(0), 8'h77, 10, 1'b0);
    send_cmd(2'd1, AW'(0), 8'h77, CW'(64));
    repeat (9) @(negedge clk_i);
    n_cmp++;
    if (wr_enable_o !== 1'b1 || wr_addr_o !== AW'(9) || done_o !== 1'b0) begin
      n_mis++;
      $display("FAIL tenth_write: got we=%b addr=%0d done=%b, required 1 9 0",
               wr_enable_o, wr_addr_o, done_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++;
    if (wr_enable_o !== 1'b0 || done_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_run_reset: got we=%b done=%b ready=%b, required 0 0 0",
               wr_enable_o, done_o, cmd_ready_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || wr_enable_o !== 1'b0 || done_o !== 1'b0 ||
        wr_addr_o !== '0 || exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL after_reset: got ready=%b we=%b done=%b addr=%0d pending=%0d, required 1 0 0 0 0",
               cmd_ready_o, wr_enable_o, done_o, wr_addr_o, exp_q.size());
    end
    test_write(AW'(33), 8'hE1);
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'd0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    cmd_len_i   = '0;
    fork
      monitor_writes();
    join_none
    @(negedge clk_i);

    test_reset();
    test_write(AW'(5), 8'hA3);
    test_fill_top();
    test_reject("fill_overflow", 2'd1, AW'(61), CW'(4));
    test_reject("fill_len_zero", 2'd1, AW'(10), CW'(0));
    test_reject("op_three",      2'd3, AW'(5),  CW'(1));
    test_reject("op_two",        2'd2, AW'(0),  CW'(1));
    test_reject("fill_len_big",  2'd1, AW'(0),  CW'(65));
    test_back_to_back();
    test_reset_during_run();

    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got pending=%0d, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
